pbvi_loop_ctrl: RTL

// - Iteration driver for the PBVI backup pipeline (step1->step2->step3).
// - Loads an initial alpha set and pulses the pipeline's en. Captures alpha_out/point_action on en_loop.
// - Checks element-wise convergence against epsilon, then feeds the new alphas back as alpha_in.
// - Stops on convergence, max_iter or watchdog timeout. Exposes the final policy (one action per belief point).

---
 rtl/pbvi_pkg.sv | 33 +++
 rtl/pbvi_delta_cmp.sv | 22 ++
 rtl/pbvi_loop_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pbvi_pkg.sv
// Shared types and constants for the PBVI iteration controller and its
// element-wise convergence comparator.
package pbvi_pkg;

  localparam int NUM_PTS  = 16;
  localparam int NUM_ST   = 2;
  localparam int NUM_ACT  = 3;
  localparam int WORD_W   = 16;
  localparam int ITER_W   = 8;
  localparam int WDOG_CYC = 1024;
  localparam int WDOG_W   = $clog2(WDOG_CYC);
  localparam int IDX_W    = $clog2(NUM_PTS);

  typedef logic [1:0] action_t;
  typedef logic [0:NUM_ST-1][WORD_W-1:0] alpha_row_t;
  typedef logic [0:NUM_PTS-1][0:NUM_ST-1][WORD_W-1:0] alpha_set_t;
  typedef logic [0:NUM_PTS-1][1:0] policy_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KICK,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } loop_state_e;

  // Unsigned distance between two words; never wraps.
  function automatic logic [WORD_W-1:0] word_abs_diff(input logic [WORD_W-1:0] a,
                                                      input logic [WORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/pbvi_delta_cmp.sv
// Flags a belief point whose alpha row moved by more than epsilon in any state.
module pbvi_delta_cmp
  import pbvi_pkg::*;
(
  input  logic [0:NUM_ST-1][WORD_W-1:0] row_a,
  input  logic [0:NUM_ST-1][WORD_W-1:0] row_b,
  input  logic [WORD_W-1:0]             epsilon,
  output logic                          exceeds
);

  logic [NUM_ST-1:0] st_exceeds;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ST; gi++) begin : g_st
      assign st_exceeds[gi] = (word_abs_diff(row_a[gi], row_b[gi]) > epsilon);
    end
  endgenerate

  assign exceeds = |st_exceeds;

endmodule

// File: rtl/pbvi_loop_ctrl.sv
// Drives repeated PBVI backups: kicks the pipeline, captures its result, scans
// for convergence one point per cycle, and feeds the new alphas back.
module pbvi_loop_ctrl
  import pbvi_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [ITER_W-1:0]                    max_iter,
  input  logic [WORD_W-1:0]                    epsilon,
  input  logic [0:NUM_PTS-1][0:NUM_ST-1][WORD_W-1:0] alpha_init,
  input  logic                                 en_loop,
  input  logic [0:NUM_PTS-1][0:NUM_ST-1][WORD_W-1:0] alpha_out,
  input  logic [0:NUM_PTS-1][1:0]              point_action,
  output logic                                 en,
  output logic [0:NUM_PTS-1][0:NUM_ST-1][WORD_W-1:0] alpha_in,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 converged,
  output logic                                 timeout,
  output logic [ITER_W-1:0]                    iter_count,
  output logic [0:NUM_PTS-1][1:0]              policy
);

  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_PTS - 1);

  loop_state_e       state_q, state_d;
  alpha_set_t        alpha_in_q, alpha_in_d;
  alpha_set_t        shadow_q, shadow_d;
  policy_t           policy_q, policy_d;
  logic [ITER_W-1:0] max_iter_q, max_iter_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [WORD_W-1:0] eps_q, eps_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [IDX_W-1:0]  scan_q, scan_d;
  logic              mismatch_q, mismatch_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              conv_q, conv_d;
  logic              timeout_q, timeout_d;
  logic              row_exceeds;

  pbvi_delta_cmp u_cmp (
    .row_a   (shadow_q[scan_q]),
    .row_b   (alpha_in_q[scan_q]),
    .epsilon (eps_q),
    .exceeds (row_exceeds)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      alpha_in_q <= '0;
      shadow_q   <= '0;
      policy_q   <= '0;
      max_iter_q <= '0;
      iter_q     <= '0;
      eps_q      <= '0;
      wdog_q     <= '0;
      scan_q     <= '0;
      mismatch_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      conv_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alpha_in_q <= alpha_in_d;
      shadow_q   <= shadow_d;
      policy_q   <= policy_d;
      max_iter_q <= max_iter_d;
      iter_q     <= iter_d;
      eps_q      <= eps_d;
      wdog_q     <= wdog_d;
      scan_q     <= scan_d;
      mismatch_q <= mismatch_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      conv_q     <= conv_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    alpha_in_d = alpha_in_q;
    shadow_d   = shadow_q;
    policy_d   = policy_q;
    max_iter_d = max_iter_q;
    iter_d     = iter_q;
    eps_d      = eps_q;
    wdog_d     = wdog_q;
    scan_d     = scan_q;
    mismatch_d = mismatch_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    conv_d     = conv_q;
    timeout_d  = timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          max_iter_d = max_iter;
          eps_d      = epsilon;
          alpha_in_d = alpha_init;
          iter_d     = '0;
          conv_d     = 1'b0;
          timeout_d  = 1'b0;
          busy_d     = 1'b1;
          state_d    = (max_iter == '0) ? ST_DONE : ST_KICK;
        end
      end
      ST_KICK: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        // A result arriving on the expiry cycle still counts.
        if (en_loop) begin
          shadow_d   = alpha_out;
          policy_d   = point_action;
          iter_d     = iter_q + 1'b1;
          scan_d     = '0;
          mismatch_d = 1'b0;
          state_d    = ST_CHECK;
        end else if (wdog_d == WDOG_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_CHECK: begin
        mismatch_d = mismatch_q | row_exceeds;
        scan_d     = scan_q + 1'b1;
        if (scan_q == LAST_IDX) begin
          alpha_in_d = shadow_q;
          if (!mismatch_d) begin
            conv_d  = 1'b1;
            state_d = ST_DONE;
          end else if (iter_q == max_iter_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_KICK;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign en         = (state_q == ST_KICK);
  assign alpha_in   = alpha_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign converged  = conv_q;
  assign timeout    = timeout_q;
  assign iter_count = iter_q;
  assign policy     = policy_q;

endmodule
